// File: rtl/uart_receiver.sv
// uart_receiver: serial-to-parallel UART receiver, 8N1 by default.
// The rx pin is synchronised, and each start edge re-phases a baud counter to
// mid-bit. Each received byte is offered on a valid/ready pair. Framing
// errors and overruns are signalled as single-cycle pulses.
// Optional feature: define UART_RX_PARITY_EN to add one even-parity bit after
// the data bits. A parity mismatch then pulses parity_error.
module uart_receiver #(
    parameter int CLK_HZ    = 25_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun,
    output logic                 parity_error
);

    localparam int DIVISOR = CLK_HZ / BAUD_RATE;
    localparam int CNT_W   = $clog2(DIVISOR) + 2;
    localparam int IDX_W   = $clog2(DATA_BITS) + 1;
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(DIVISOR);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIVISOR / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK_WAIT
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic                   rx_meta;
    logic                   rx_sync;
    logic                   rx_prev;
    logic [CNT_W-1:0]       count;
    logic                   tick;
    logic                   load_count;
    logic                   sample_data;
    logic                   stop_good;
    logic                   stop_bad;
    logic [IDX_W-1:0]       bit_idx;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   commit_pending;
    logic                   frame_ok;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection; idles high.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign tick = (count == CNT_TOP);

    // Baud counter: half-period load on a start edge; wraps to 1 so one bit spans DIVISOR clocks.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load_count) begin
            count <= CNT_HALF;
        end else if (tick) begin
            count <= CNT_ONE;
        end else begin
            count <= count + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and per-cycle strobes for the datapath.
    always_comb begin
        next_state  = state;
        load_count  = 1'b0;
        sample_data = 1'b0;
        stop_good   = 1'b0;
        stop_bad    = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    load_count = 1'b1;
                    next_state = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    next_state = rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    sample_data = 1'b1;
                    if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        next_state = S_PARITY;
`else
                        next_state = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    next_state = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (rx_sync) begin
                        stop_good  = 1'b1;
                        next_state = S_IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        next_state = S_BREAK_WAIT;
                    end
                end
            end
            S_BREAK_WAIT: begin
                if (rx_sync) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic parity_bad;

    // Latch the even-parity check; report a mismatch only for frames whose stop bit was good.
    always_ff @(posedge clock) begin
        if (reset) begin
            parity_bad   <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            if (state == S_PARITY && tick) begin
                parity_bad <= (rx_sync != ^shift_reg);
            end
            parity_error <= commit_pending && parity_bad;
        end
    end

    assign frame_ok = commit_pending && !parity_bad;
`else
    assign frame_ok     = commit_pending;
    assign parity_error = 1'b0;
`endif

    // Shift in data bits and hand good frames to the output buffer one cycle after the stop tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_idx        <= '0;
            shift_reg      <= '0;
            commit_pending <= 1'b0;
            data           <= '0;
            data_valid     <= 1'b0;
            framing_error  <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            framing_error  <= stop_bad;
            commit_pending <= stop_good;
            overrun        <= 1'b0;
            if (state == S_START) begin
                bit_idx <= '0;
            end else if (sample_data) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (sample_data) begin
                shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
            end
            if (frame_ok) begin
                if (!data_valid || data_ready) begin
                    data       <= shift_reg;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: drives whole UART frames, including directed and random cases.
// It checks every cycle against a frame-level scoreboard of expected outcomes.
module tb_uart_receiver;

    localparam int CLK_HZ = 153_600;
    localparam int BAUD   = 9600;
    localparam int DW     = 8;
    localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS  = 1;
`else
    localparam int PBITS  = 0;
`endif
    localparam int FBITS  = 1 + DW + PBITS + 1;
    localparam int LAT_NOM = (DW + PBITS + 1) * DIV + DIV / 2 + 4;

    localparam int K_GOOD   = 1;
    localparam int K_FRAME  = 2;
    localparam int K_PARITY = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          rx = 1'b1;
    logic          data_ready = 1'b1;
    logic [DW-1:0] data;
    logic          data_valid;
    logic          framing_error;
    logic          overrun;
    logic          parity_error;

    uart_receiver #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(DW)) dut (
        .clock(clock),
        .reset(reset),
        .rx(rx),
        .data(data),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .framing_error(framing_error),
        .overrun(overrun),
        .parity_error(parity_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            kind;
        logic [DW-1:0] b;
        int            lo;
        int            hi;
    } exp_t;

    exp_t          expq[$];
    int            cyc = 0;
    logic          rst_edge = 1'b0;
    int            total = 0;
    int            bad = 0;
    bit            check_on = 1'b0;
    logic          m_full = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic          prev_ready = 1'b1;
    int            n_load = 0;
    int            n_fe = 0;
    int            n_pe = 0;
    int            n_ov = 0;
    int            last_load_cyc = 0;
    logic [DW-1:0] last_load_data = '0;
    int            last_edge = 0;

    // Cycle counter and a record of whether the last edge saw reset.
    always @(posedge clock) begin
        cyc      <= cyc + 1;
        rst_edge <= reset;
    end

    // Scoreboard compare: buffer model, hold rule, and frame outcomes inside their windows.
    always @(negedge clock) begin : compare
        logic acc, keep, nl, ok, w_nl, w_fe, w_pe, w_ov;
        exp_t e;
        if (rst_edge) begin
            total++;
            if (data !== '0 || data_valid !== 1'b0 || framing_error !== 1'b0 ||
                overrun !== 1'b0 || parity_error !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_outputs: got data=%h valid=%b fe=%b ov=%b pe=%b want all 0",
                         data, data_valid, framing_error, overrun, parity_error);
            end
            expq.delete();
            m_full = 1'b0;
        end else if (check_on) begin
            acc  = m_full && prev_ready;
            keep = m_full && !acc;
            nl   = data_valid && !keep;
            if (keep) begin
                total++;
                if (data_valid !== 1'b1 || data !== m_data) begin
                    bad++;
                    $display("[TB] FAIL hold: got valid=%b data=%h want valid=1 data=%h",
                             data_valid, data, m_data);
                end
            end
            if (expq.size() > 0 && cyc > expq[0].hi) begin
                total++;
                bad++;
                $display("[TB] FAIL missing_event: got nothing by cycle %0d want kind=%0d byte=%h",
                         cyc, expq[0].kind, expq[0].b);
                void'(expq.pop_front());
            end
            if (nl || framing_error || overrun || parity_error) begin
                if (nl) n_load++;
                if (framing_error) n_fe++;
                if (parity_error) n_pe++;
                if (overrun) n_ov++;
                total++;
                ok = 1'b0;
                w_nl = 1'b0; w_fe = 1'b0; w_pe = 1'b0; w_ov = 1'b0;
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    case (e.kind)
                        K_GOOD:  if (keep) w_ov = 1'b1; else w_nl = 1'b1;
                        K_FRAME: w_fe = 1'b1;
                        default: w_pe = 1'b1;
                    endcase
                    ok = (cyc >= e.lo) && (cyc <= e.hi) && (nl == w_nl) &&
                         (framing_error == w_fe) && (parity_error == w_pe) &&
                         (overrun == w_ov) && (!w_nl || data == e.b);
                end
                if (!ok) begin
                    bad++;
                    $display("[TB] FAIL event: cycle %0d got load=%b data=%h fe=%b pe=%b ov=%b want kind=%0d byte=%h in [%0d,%0d]",
                             cyc, nl, data, framing_error, parity_error, overrun,
                             e.kind, e.b, e.lo, e.hi);
                end
                if (nl) begin
                    m_data         = ok ? e.b : data;
                    last_load_cyc  = cyc;
                    last_load_data = data;
                end
            end
            m_full = keep || nl;
        end
        prev_ready = data_ready;
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drive one frame and queue its expected outcome; abort_bit >= 0 pulses reset mid data bit.
    task automatic send_frame(input logic [DW-1:0] b, input logic stop_bit,
                              input logic par_flip, input int abort_bit);
        logic [FBITS-1:0] bits;
        exp_t e;
        bits = '0;
        for (int i = 0; i < DW; i++) bits[1 + i] = b[i];
        if (PBITS > 0) bits[1 + DW] = (^b) ^ par_flip;
        bits[FBITS - 1] = stop_bit;
        @(posedge clock);
        #1;
        last_edge = cyc;
        e.kind = !stop_bit ? K_FRAME : ((par_flip && PBITS > 0) ? K_PARITY : K_GOOD);
        e.b    = b;
        e.lo   = cyc + FBITS * DIV - 12;
        e.hi   = cyc + FBITS * DIV + 6;
        expq.push_back(e);
        for (int i = 0; i < FBITS; i++) begin
            rx = bits[i];
            for (int c = 0; c < DIV; c++) begin
                reset = (abort_bit >= 0 && i == abort_bit + 1 && c == 8);
                @(posedge clock);
                #1;
            end
        end
        reset = 1'b0;
        rx    = 1'b1;
    endtask

    initial begin : stim
        int n0, f0, p0, o0, lat;
        logic [DW-1:0] rb;
        logic rs, rp;
        reset = 1'b1;
        rx = 1'b1;
        data_ready = 1'b1;
        tick_n(3);
        reset = 1'b0;
        check_on = 1'b1;
        tick_n(5);
        check("reset_valid", data_valid, 0);
        check("reset_data", data, 0);

        // Clean 0xA5 with consumer ready
        n0 = n_load;
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        tick_n(20);
        check("a5_loads", n_load - n0, 1);
        check("a5_data", last_load_data, 8'hA5);
        lat = last_load_cyc - last_edge;
        check("a5_latency", (lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1) ? 1 : 0, 1);

        // Glitch shorter than half a bit
        n0 = n_load + n_fe + n_pe + n_ov;
        rx = 1'b0;
        tick_n(4);
        rx = 1'b1;
        tick_n(40);
        check("false_start_quiet", n_load + n_fe + n_pe + n_ov - n0, 0);

        // Framing error, then a clean copy
        n0 = n_load; f0 = n_fe;
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        tick_n(20);
        check("fe_pulses", n_fe - f0, 1);
        check("fe_no_load", n_load - n0, 0);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        tick_n(20);
        check("after_fe_data", last_load_data, 8'h3C);

        // Overrun with consumer stalled
        data_ready = 1'b0;
        o0 = n_ov;
        send_frame(8'h11, 1'b1, 1'b0, -1);
        tick_n(15);
        send_frame(8'h22, 1'b1, 1'b0, -1);
        tick_n(15);
        check("ovr_pulses", n_ov - o0, 1);
        check("ovr_held_data", data, 8'h11);
        check("ovr_held_valid", data_valid, 1);
        data_ready = 1'b1;
        tick_n(2);
        check("ovr_drain_valid", data_valid, 0);

        // Reset during data bit 4 while a byte sits in the buffer
        data_ready = 1'b0;
        send_frame(8'h77, 1'b1, 1'b0, -1);
        tick_n(15);
        check("pre_reset_valid", data_valid, 1);
        send_frame(8'hFF, 1'b1, 1'b0, 4);
        tick_n(2);
        check("post_reset_valid", data_valid, 0);
        check("post_reset_data", data, 0);
        data_ready = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        tick_n(20);
        check("after_reset_data", last_load_data, 8'h5A);

`ifdef UART_RX_PARITY_EN
        // Bad parity bit, then the correct parity bit
        n0 = n_load; p0 = n_pe;
        send_frame(8'h07, 1'b1, 1'b1, -1);
        tick_n(20);
        check("par_pulses", n_pe - p0, 1);
        check("par_no_load", n_load - n0, 0);
        send_frame(8'h07, 1'b1, 1'b0, -1);
        tick_n(20);
        check("par_good_data", last_load_data, 8'h07);
`else
        p0 = n_pe;
`endif

        // Random traffic
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                rx = 1'b0;
                tick_n($urandom_range(1, 5));
                rx = 1'b1;
                tick_n(30);
            end
            data_ready = ($urandom_range(0, 3) != 0);
            rb = DW'($urandom);
            rs = ($urandom_range(0, 5) != 0);
            rp = (PBITS > 0) ? ($urandom_range(0, 4) == 0) : 1'b0;
            send_frame(rb, rs, rp, -1);
            tick_n($urandom_range(12, 40));
        end
        data_ready = 1'b1;
        tick_n(50);
        check("queue_drained", expq.size(), 0);
`ifndef UART_RX_PARITY_EN
        check("parity_never", n_pe - p0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
